// File: rtl/prog_store.sv
// prog_store: writable 16x8 program memory for the 4-bit CPU.
// The CPU fetches combinationally through `address`/`instr`. A nibble-serial
// loader, driven from slow asynchronous pins, rewrites the memory while the
// CPU is held in reset through `cpu_rst_n`.
//
// Ports
//   clk        in   system clock
//   n_reset    in   asynchronous active-low reset
//   address    in   [3:0] fetch address (CPU program counter)
//   instr      out  [7:0] mem[address] in RUN, 0x00 while loading
//   prog_mode  in   asynchronous level, high selects loading
//   nib_stb    in   asynchronous strobe, each rising edge presents a nibble
//   nib_data   in   [3:0] nibble value, stable around the strobe
//   cpu_rst_n  out  registered active-low CPU reset, low while loading
//   load_ptr   out  [3:0] next byte address the loader writes
//   full       out  sticky, set once all 16 bytes written this session
//
// Build option: define PROG_STORE_DEFAULT_ROM_EN to reset the memory to the
// timer demo image; otherwise reset clears every byte to 0x00.
//
// state | meaning
// ------+---------------------------------------------------------
// RUN   | CPU running, memory readable, loader idle
// LD_LO | loading, waiting for the low nibble of the next byte
// LD_HI | loading, low nibble held, waiting for the high nibble

module prog_store (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [3:0] address,
    output logic [7:0] instr,
    input  logic       prog_mode,
    input  logic       nib_stb,
    input  logic [3:0] nib_data,
    output logic       cpu_rst_n,
    output logic [3:0] load_ptr,
    output logic       full
);

    typedef enum logic [1:0] {RUN, LD_LO, LD_HI} state_t;

`ifdef PROG_STORE_DEFAULT_ROM_EN
    localparam logic [7:0] ROM_IMG [16] = '{
        8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
        8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF
    };
`else
    localparam logic [7:0] ROM_IMG [16] = '{default: 8'h00};
`endif

    state_t     state;
    logic [7:0] mem [16];
    logic [3:0] low_nib;

    logic pm_q1, pm_s;
    logic stb_q1, stb_s, stb_d;
    logic stb_rise;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pm_q1  <= 1'b0;
            pm_s   <= 1'b0;
            stb_q1 <= 1'b0;
            stb_s  <= 1'b0;
            stb_d  <= 1'b0;
        end else begin
            pm_q1  <= prog_mode;
            pm_s   <= pm_q1;
            stb_q1 <= nib_stb;
            stb_s  <= stb_q1;
            stb_d  <= stb_s;
        end
    end

    assign stb_rise = stb_s & ~stb_d;

    // Memory lives in the same reset domain so a reset mid-load restores
    // the build's default image.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= RUN;
            load_ptr  <= 4'd0;
            full      <= 1'b0;
            low_nib   <= 4'd0;
            cpu_rst_n <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem[i] <= ROM_IMG[i];
            end
        end else begin
            cpu_rst_n <= (state == RUN);
            case (state)
                RUN: begin
                    if (pm_s) begin
                        state    <= LD_LO;
                        load_ptr <= 4'd0;
                        full     <= 1'b0;
                        low_nib  <= 4'd0;
                    end
                end
                LD_LO: begin
                    // Exit takes priority over a coincident strobe.
                    if (!pm_s) begin
                        state <= RUN;
                    end else if (stb_rise) begin
                        low_nib <= nib_data;
                        state   <= LD_HI;
                    end
                end
                LD_HI: begin
                    if (!pm_s) begin
                        state <= RUN;
                    end else if (stb_rise) begin
                        mem[load_ptr] <= {nib_data, low_nib};
                        load_ptr      <= load_ptr + 4'd1;
                        if (load_ptr == 4'hF) begin
                            full <= 1'b1;
                        end
                        state <= LD_LO;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Blank the fetch port while loading so a half-written image is never run.
    assign instr = (state == RUN) ? mem[address] : 8'h00;

endmodule

// File: tb/tb_prog_store.sv
module tb_prog_store;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [3:0] address;
    logic [7:0] instr;
    logic       prog_mode;
    logic       nib_stb;
    logic [3:0] nib_data;
    logic       cpu_rst_n;
    logic [3:0] load_ptr;
    logic       full;

    always #5 clk = ~clk;

    prog_store dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .address   (address),
        .instr     (instr),
        .prog_mode (prog_mode),
        .nib_stb   (nib_stb),
        .nib_data  (nib_data),
        .cpu_rst_n (cpu_rst_n),
        .load_ptr  (load_ptr),
        .full      (full)
    );

`ifdef PROG_STORE_DEFAULT_ROM_EN
    localparam logic [7:0] IMG [16] = '{
        8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
        8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF
    };
`else
    localparam logic [7:0] IMG [16] = '{default: 8'h00};
`endif

    // Reference model: memory contents, next write address, sticky full.
    logic [7:0] m_mem [16];
    int         m_ptr;
    logic       m_full;

    // Scoreboard. kind: 0 instr, 1 cpu_rst_n, 2 load_ptr, 3 full
    typedef struct {
        int         kind;
        logic [7:0] exp;
        int         tag;
    } exp_t;
    exp_t sb[$];
    exp_t cur;
    logic [7:0] act;
    string      nm;
    int errors = 0;
    int checks = 0;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            case (cur.kind)
                0:       begin act = instr;                nm = "instr";     end
                1:       begin act = {7'd0, cpu_rst_n};    nm = "cpu_rst_n"; end
                2:       begin act = {4'd0, load_ptr};     nm = "load_ptr";  end
                default: begin act = {7'd0, full};         nm = "full";      end
            endcase
            checks++;
            if (act !== cur.exp) begin
                errors++;
                $display("FAIL %s tag=%0d actual=%02h expected=%02h",
                         nm, cur.tag, act, cur.exp);
            end
        end
    end

    task automatic expect_out(input int kind, input logic [7:0] v, input int tag);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.tag  = tag;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = IMG[i];
        m_ptr  = 0;
        m_full = 1'b0;
    endtask

    task automatic model_write(input logic [7:0] b);
        m_mem[m_ptr] = b;
        if (m_ptr == 15) m_full = 1'b1;
        m_ptr = (m_ptr + 1) % 16;
    endtask

    task automatic send_nib(input logic [3:0] n, input int hi, input int lo);
        @(posedge clk);
        #1;
        nib_data = n;
        nib_stb  = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        nib_stb = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[3:0], 3, 3);
        send_nib(b[7:4], 3, 3);
        model_write(b);
    endtask

    task automatic enter_load();
        @(posedge clk);
        #1;
        prog_mode = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        m_ptr  = 0;
        m_full = 1'b0;
    endtask

    task automatic exit_load();
        @(posedge clk);
        #1;
        prog_mode = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic check_ptr_full(input int tag);
        expect_out(2, 8'(m_ptr), tag);
        expect_out(3, {7'd0, m_full}, tag);
    endtask

    task automatic check_loading(input int tag);
        address = 4'($urandom_range(0, 15));
        expect_out(0, 8'h00, tag);
        expect_out(1, 8'h00, tag);
    endtask

    task automatic sweep(input int tag);
        int start;
        int a;
        start = $urandom_range(0, 15);
        for (int i = 0; i < 16; i++) begin
            a = (start + i) % 16;
            address = 4'(a);
            expect_out(0, m_mem[a], tag * 100 + a);
        end
    endtask

    task automatic apply_reset(input int tag);
        n_reset   = 1'b0;
        prog_mode = 1'b0;
        nib_stb   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_out(1, 8'h00, tag);
        check_ptr_full(tag);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        expect_out(1, 8'h00, tag);
        expect_out(1, 8'h01, tag);
    endtask

    initial begin
        logic [7:0] b;
        int n;

        n_reset   = 1'b0;
        address   = 4'd0;
        prog_mode = 1'b0;
        nib_stb   = 1'b0;
        nib_data  = 4'd0;

        // Reset and default image
        apply_reset(1);
        sweep(1);

        // Single byte 5,A -> A5
        enter_load();
        check_loading(2);
        check_ptr_full(2);
        send_byte(8'hA5);
        check_loading(3);
        check_ptr_full(3);
        exit_load();
        expect_out(1, 8'h01, 4);
        sweep(4);

        // 17 bytes 00..10 with wrap
        enter_load();
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i));
            if (i == 14 || i == 15 || i == 16) check_ptr_full(500 + i);
        end
        check_loading(5);
        exit_load();
        sweep(6);

        // Half byte then abort; memory unchanged
        enter_load();
        check_ptr_full(7);
        send_nib(4'h7, 3, 3);
        exit_load();
        expect_out(1, 8'h01, 8);
        sweep(8);
        enter_load();
        check_ptr_full(9);

        // Reset mid-load in LD_HI after 3 bytes
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        check_ptr_full(10);
        send_nib(4'h3, 3, 3);
        apply_reset(11);
        sweep(11);

        // Minimum strobe timing: 2 high / 2 low registers one nibble each
        enter_load();
        send_nib(4'hC, 2, 2);
        send_nib(4'h6, 2, 2);
        model_write(8'h6C);
        check_ptr_full(12);
        exit_load();
        sweep(12);

        // Randomised sessions
        for (int s = 0; s < 4; s++) begin
            enter_load();
            check_ptr_full(20 + s);
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                send_byte(b);
            end
            check_ptr_full(30 + s);
            if ($urandom_range(0, 1) == 1) send_nib(4'($urandom), 3, 3);
            check_loading(40 + s);
            exit_load();
            expect_out(1, 8'h01, 50 + s);
            sweep(60 + s);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
